// File: rtl/xor_stream_cipher.sv
// Registered, handshaked XOR stream cipher: XORs each accepted beat with a working key,
// optionally rotating the key one lane per beat, and counts beats since reset/key load.
module xor_stream_cipher #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [0:DATA_W-1] key_in,
  input  logic              rotate_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] data_out,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int NLANES = DATA_W / LANE_W;

  logic [0:DATA_W-1] key_reg;
  logic [0:DATA_W-1] data_reg;
  logic              valid_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [0:DATA_W-1] xored;
  logic [0:DATA_W-1] rotated;
  logic              accept;

  // A stalled result only blocks intake while downstream is not taking it.
  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Lane 0 is the leftmost lane; rotation moves lane i+1 into lane i, old lane 0 to the end.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign xored[gi*LANE_W +: LANE_W]   = data_in[gi*LANE_W +: LANE_W] ^ key_reg[gi*LANE_W +: LANE_W];
    assign rotated[gi*LANE_W +: LANE_W] = key_reg[((gi + 1) % NLANES)*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      if (accept) begin
        data_reg  <= xored;
        valid_reg <= 1'b1;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end

      // A key load wins: a beat accepted alongside it used the old key and is not counted.
      if (key_load) begin
        key_reg <= key_in;
        cnt_reg <= '0;
      end else if (accept) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (rotate_en) begin
          key_reg <= rotated;
        end
      end
    end
  end

  assign out_valid = valid_reg;
  assign data_out  = data_reg;
  assign beat_cnt  = cnt_reg;

endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
Streaming, parametrised XOR encrypt/decrypt engine. It is the registered, handshaked successor of the team's fixed 64-bit combinational lane XOR.
- Holds a loadable working key.
- XORs each accepted data beat lane-by-lane against that key.
- Optionally rotates the key by one lane after every beat (rolling-key mode).
- Counts processed beats.
- Sits between the ballot-record packer and the storage/link interface, one instance per direction.

Parameters:
DATA_W, 64, beat and key width in bits; must be a multiple of LANE_W.
LANE_W, 8, lane width in bits; NLANES = DATA_W/LANE_W.
CNT_W, 16, width of the beat counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
key_load  input  1  load key_in into the working key this cycle.
key_in  input  [0:DATA_W-1]  new key value.
rotate_en  input  1  1 = rolling-key mode, 0 = static key; sampled on each accepted beat.
in_valid  input  1  upstream beat valid.
in_ready  output  1  block can accept a beat.
data_in  input  [0:DATA_W-1]  plaintext or ciphertext beat.
out_valid  output  1  output register holds a result.
out_ready  input  1  downstream accepts the result.
data_out  output  [0:DATA_W-1]  XOR result.
beat_cnt  output  [CNT_W-1:0]  number of beats accepted since reset or the last key_load.

Behaviour:
- Bit order: index 0 is the MSB. Lane i occupies bits [i*LANE_W : i*LANE_W+LANE_W-1]. Lane 0 is the leftmost lane.
- Reset (asynchronous, immediate):
  - working key = 0
  - data_out = 0
  - out_valid = 0
  - beat_cnt = 0
  - in_ready reflects the reset state, so it is 1.
  - Any in-flight result is discarded.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - The result is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is combinational and gives full throughput with no bubble.
- Datapath:
  - On an accepted beat, data_out <= data_in ^ working_key (bitwise, all lanes) and out_valid <= 1.
  - Latency is exactly 1 cycle from acceptance to out_valid.
  - If out_valid && out_ready and no new beat is accepted, out_valid <= 0 and data_out holds its last value.
- While out_valid=1 && out_ready=0, data_out and out_valid hold stable and in_ready=0.
- Key schedule, evaluated per cycle in this priority order:
  1. key_load=1: working key <= key_in and beat_cnt <= 0. If a beat is accepted in the same cycle, that beat uses the OLD key and no rotation occurs.
  2. Otherwise, if a beat is accepted and rotate_en=1: working key <= rotate-left by one lane, i.e. {key[LANE_W:DATA_W-1], key[0:LANE_W-1]}. The old lane 0 becomes the last lane.
  3. Otherwise the key holds.
- beat_cnt:
  - Increments by 1 on each accepted beat, except in a key_load cycle.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Decryption is the same operation. Two instances with the same key, rotate_en and beat sequence recover the original data.
- No combinational path from data_in to data_out. The only combinational output path is out_ready -> in_ready.

Test Plan:
- Reset then static key: key_load with key_in=64'h0102030405060708, rotate_en=0; send data_in=64'hFFFFFFFFFFFFFFFF -> one cycle later out_valid=1, data_out=64'hFEFDFCFBFAF9F8F7, beat_cnt=1.
- Rolling key: key=64'h0102030405060708, rotate_en=1, two back-to-back beats of 64'h0 with out_ready=1 -> data_out=64'h0102030405060708, then 64'h0203040506070801; beat_cnt=2; in_ready held 1 throughout.
- Backpressure: out_ready=0 with a result pending; drive a second beat -> in_ready=0, data_out stable. Raise out_ready -> first result consumed and second beat accepted the same cycle, second result appears the next cycle.
- key_load with a simultaneous accepted beat: old key 64'hAA..AA, key_in=64'h55..55, data_in=0, rotate_en=1 -> data_out=64'hAAAAAAAAAAAAAAAA, new working key=64'h5555555555555555 (not rotated), beat_cnt=0.
- Round trip: encrypt 4 beats with rotate_en=1 through one instance, feed the outputs to a second instance loaded with the same key -> the original 4 beats are returned.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid=0, data_out=0 and beat_cnt=0 immediately. After release the working key is 0, so data passes unchanged.
